// File: rtl/crc_check.sv
// Receive-side LCRC checker: recomputes CRC-32 bit-serially (MSB first) over the TLP
// and reports match/mismatch with the received LCRC through a valid/ready handshake.
module crc_check #(
    parameter int unsigned TLP_W = 96,
    parameter int unsigned CRC_W = 32,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter logic [31:0] INIT  = 32'hFFFFFFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TLP_W+CRC_W-1:0]   frame_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TLP_W-1:0]         tlp_out,
    output logic [CRC_W-1:0]         crc_calc,
    output logic                     crc_ok,
    output logic                     crc_err,
    output logic [7:0]               err_cnt
);

    localparam int unsigned FRAME_W  = TLP_W + CRC_W;
    localparam int unsigned CNT_W    = 7;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TLP_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [TLP_W-1:0] tlp_q,       tlp_d;
    logic [CRC_W-1:0] rx_crc_q,    rx_crc_d;
    logic [CRC_W-1:0] lfsr_q,      lfsr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [TLP_W-1:0] tlp_out_q,   tlp_out_d;
    logic [CRC_W-1:0] crc_calc_q,  crc_calc_d;
    logic             crc_ok_q,    crc_ok_d;
    logic             crc_err_q,   crc_err_d;
    logic [7:0]       err_cnt_q,   err_cnt_d;

    logic [CNT_W-1:0] bit_idx;
    logic             data_bit;
    logic             fb;
    logic [CRC_W-1:0] lfsr_step;
    logic             match;

    // One LFSR step over the current TLP bit, walking from the MSB down.
    always_comb begin
        bit_idx   = LAST_CNT - cnt_q;
        data_bit  = tlp_q[bit_idx];
        fb        = lfsr_q[CRC_W-1] ^ data_bit;
        lfsr_step = {lfsr_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY[CRC_W-1:0] : '0);
        match     = (lfsr_step == rx_crc_q);
    end

    always_comb begin
        state_d     = state_q;
        tlp_d       = tlp_q;
        rx_crc_d    = rx_crc_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        tlp_out_d   = tlp_out_q;
        crc_calc_d  = crc_calc_q;
        crc_ok_d    = crc_ok_q;
        crc_err_d   = crc_err_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    tlp_d      = frame_in[FRAME_W-1:CRC_W];
                    rx_crc_d   = frame_in[CRC_W-1:0];
                    lfsr_d     = INIT[CRC_W-1:0];
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                lfsr_d = lfsr_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    tlp_out_d   = tlp_q;
                    crc_calc_d  = lfsr_step;
                    crc_ok_d    = match;
                    crc_err_d   = !match;
                    if (!match && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                // Result is held until the consumer takes it; no new frame meanwhile.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    crc_ok_d    = 1'b0;
                    crc_err_d   = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                crc_ok_d    = 1'b0;
                crc_err_d   = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tlp_q       <= '0;
            rx_crc_q    <= '0;
            lfsr_q      <= INIT[CRC_W-1:0];
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            tlp_out_q   <= '0;
            crc_calc_q  <= '0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tlp_q       <= tlp_d;
            rx_crc_q    <= rx_crc_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            tlp_out_q   <= tlp_out_d;
            crc_calc_q  <= crc_calc_d;
            crc_ok_q    <= crc_ok_d;
            crc_err_q   <= crc_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign tlp_out   = tlp_out_q;
    assign crc_calc  = crc_calc_q;
    assign crc_ok    = crc_ok_q;
    assign crc_err   = crc_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
